if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Instruction buffer between fetch and decode: stores {PC, instruction} pairs produced each cycle by the fetch stage and the instruction memory.
- Presents entries in order to the decode stage under a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions; backpressures fetch when full.
- Discards all buffered entries on a flush (taken branch or exception redirect).

Parameters:
- N, 64, address/PC width (matches fetch datapath).
- IW, 32, instruction word width.
- DEPTH, 4, number of entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Valid_F  in  1  fetch offers an entry this cycle.
- PC_F  in  N  PC of offered instruction (fetch imem_addr_F).
- Instr_F  in  IW  instruction word returned by imem for PC_F.
- Ready_F  out  1  queue can accept an entry this cycle.
- Flush  in  1  discard all entries (branch taken / exception redirect).
- Valid_D  out  1  head entry is valid.
- PC_D  out  N  PC of head entry.
- Instr_D  out  IW  instruction of head entry.
- Ready_D  in  1  decode consumes head entry this cycle.
- Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, Count=0, so Valid_D=0 and Ready_F=1. Storage contents are don't-care.
- Interface outputs are combinational from state only:
  - Ready_F = (Count != DEPTH).
  - Valid_D = (Count != 0).
  - No input-to-output combinational paths.
- Push: occurs when Valid_F && Ready_F. Writes {PC_F, Instr_F} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: occurs when Valid_D && Ready_D. rd_ptr increments modulo DEPTH.
- First-word fall-through: an entry pushed in cycle t appears on PC_D/Instr_D with Valid_D=1 in cycle t+1.
  - Minimum latency is 1 cycle; there is no same-cycle bypass.
- When empty: PC_D = 0 and Instr_D = 0, not stale storage.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full (Count == DEPTH):
  - Ready_F = 0 even if decode pops that cycle; no pass-through when full.
  - Valid_F is ignored; fetch must hold its entry.
- Empty (Count == 0): Ready_D is ignored and nothing pops.
- Wrap-around: pointers are $clog2(DEPTH) bits and roll DEPTH-1 -> 0. Count, not pointer comparison, distinguishes full from empty.
- Flush (synchronous, highest priority):
  - Next edge sets wr_ptr=0, rd_ptr=0, Count=0.
  - Any push or pop in the flush cycle is dropped, including an entry offered on Valid_F.
  - In the cycle after flush: Valid_D=0, Ready_F=1.
- Reset asserted mid-operation: state clears asynchronously regardless of clk, and all in-flight entries are lost. On deassertion the queue behaves as after initial reset.
- Ordering: entries leave in exactly push order; no duplication, no loss except via Flush or reset.

Decomposition:
- Shared package (pipeline package) holds:
  - IW and the default N.
  - typedef fetch_entry_t packed struct {logic [N-1:0] pc; logic [IW-1:0] instr}.
  - Constant NOP_INSTR, reserved for decode-side bubble insertion (not driven by this block).
- One sub-module, wrap_counter: parameterised modulo-DEPTH pointer with enable and synchronous clear, plus async reset. It is instantiated twice, for wr_ptr and rd_ptr.
- Storage is a register array in the top module.

Test Plan:
- Reset then idle: assert reset mid-cycle -> Count=0, Valid_D=0, Ready_F=1, PC_D=0, Instr_D=0 immediately, without waiting for a clock edge.
- Single pass: push PC_F=0x100, Instr_F=0x8B020020 with Ready_D=0 -> next cycle Valid_D=1, PC_D=0x100, Instr_D=0x8B020020, Count=1. Raise Ready_D one cycle -> Count=0, Valid_D=0.
- Fill to full with Ready_D=0: push PCs 0x0, 0x4, 0x8, 0xC -> Count=4, Ready_F=0. A fifth offer (0x10) held 3 cycles is not stored. Then pop 5 times with Valid_F held -> order 0x0, 0x4, 0x8, 0xC, 0x10.
- Streaming with wrap: Valid_F=1 and Ready_D=1 continuously for 10 cycles, PCs 0x0..0x24 -> Count stays 1 after the first cycle. Decode sees every PC exactly once, in order, across pointer wrap.
- Flush with simultaneous events: Count=3 (PCs 0x40, 0x44, 0x48), assert Flush with Valid_F=1 (PC 0x4C) and Ready_D=1 -> next cycle Count=0, Valid_D=0. Next push of PC 0x200 is the next head.
- Full plus pop same cycle: Count=4, Ready_D=1, Valid_F=1 -> Ready_F=0 that cycle and Count=3 next cycle. The offered entry is accepted the following cycle.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
// Default widths, the fetch entry record and the decode bubble encoding.
package if_id_queue_pkg;

   localparam int N_DEFAULT  = 64;
   localparam int IW_DEFAULT = 32;

   typedef struct packed {
      logic [N_DEFAULT-1:0]  pc;
      logic [IW_DEFAULT-1:0] instr;
   } fetch_entry_t;

   // Bubble encoding used by decode when it inserts a stall slot.
   localparam logic [IW_DEFAULT-1:0] NOP_INSTR = 32'hD503_201F;

endpackage

// File: rtl/if_id_queue_wrap_counter.sv
// Modulo-DEPTH pointer with enable, synchronous clear and async reset.
// Used for both the write and read pointers of the fetch/decode queue.
module wrap_counter #(
   parameter int DEPTH = 4,
   parameter int W     = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   // Pointer register: clear beats advance, advance rolls LAST -> 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= {W{1'b0}};
      end else if (clr) begin
         value <= {W{1'b0}};
      end else if (en) begin
         value <= (value == LAST) ? {W{1'b0}} : value + W'(1);
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with first-word fall-through and flush.
// Occupancy count, not pointer comparison, tells full from empty.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int IW    = IW_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Valid_F,
   input  logic [N-1:0]             PC_F,
   input  logic [IW-1:0]            Instr_F,
   output logic                     Ready_F,
   input  logic                     Flush,
   output logic                     Valid_D,
   output logic [N-1:0]             PC_D,
   output logic [IW-1:0]            Instr_D,
   input  logic                     Ready_D,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [N-1:0]  pc;
      logic [IW-1:0] instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt;
   logic            push;
   logic            pop;
   entry_t          head;

   assign Ready_F = (count_r != CW'(DEPTH));
   assign Valid_D = (count_r != {CW{1'b0}});
   assign Count   = count_r;

   // A flush cycle drops both the offered entry and any consume.
   assign push = Valid_F && Ready_F && !Flush;
   assign pop  = Valid_D && Ready_D && !Flush;

   wrap_counter #(.DEPTH(DEPTH), .W(PW)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (push),
      .clr   (Flush),
      .value (wr_ptr)
   );

   wrap_counter #(.DEPTH(DEPTH), .W(PW)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (pop),
      .clr   (Flush),
      .value (rd_ptr)
   );

   // Occupancy next-state.
   always_comb begin
      count_nxt = count_r;
      if (Flush) begin
         count_nxt = {CW{1'b0}};
      end else if (push && !pop) begin
         count_nxt = count_r + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count_r - CW'(1);
      end else begin
         count_nxt = count_r;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_nxt;
      end
   end

   // Entry storage; contents are meaningful only where count says so.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: PC_F, instr: Instr_F};
      end
   end

   // Head presentation is forced to zero when empty so decode never sees stale data.
   always_comb begin
      head = mem[rd_ptr];
      if (Valid_D) begin
         PC_D    = head.pc;
         Instr_D = head.instr;
      end else begin
         PC_D    = {N{1'b0}};
         Instr_D = {IW{1'b0}};
      end
   end

endmodule
